// File: rtl/b13_serial_rx.sv
// b13_serial_rx: 8N1 serial receiver. It holds one byte under a ready/ack handshake
// and reports framing errors and overruns.
module b13_serial_rx #(
   parameter int BIT_TICKS = 16,
   parameter int CNT_W     = 7
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] dato,
   output logic       dato_ready,
   input  logic       dato_ack,
   output logic       dsr,
   output logic       frame_error,
   output logic       overrun
);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_TICKS / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_TICKS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t           state_q;
   logic             s1_q, rx_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q;
   logic [7:0]       shift_q, dato_q;
   logic             ready_q, fe_q, ovr_q;
   logic             tick, good;

   assign tick  = cnt_q == '0;
   assign good  = state_q == STOP && tick && rx_s_q;
   assign cnt_d = tick ? FULL_M1 : cnt_q - 1'b1;

   assign dato        = dato_q;
   assign dato_ready  = ready_q;
   assign dsr         = ~ready_q;
   assign frame_error = fe_q;
   assign overrun     = ovr_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         s1_q    <= 1'b1;
         rx_s_q  <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         dato_q  <= '0;
         ready_q <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         s1_q   <= rx_in;
         rx_s_q <= s1_q;
         fe_q   <= 1'b0;
         case (state_q)
            IDLE: if (!rx_s_q) begin
               cnt_q   <= HALF_M1;
               state_q <= START;
            end
            START: begin
               cnt_q <= cnt_d;
               if (tick) begin
                  idx_q   <= '0;
                  state_q <= rx_s_q ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt_q <= cnt_d;
               if (tick) begin
                  // LSB arrives first, so shifting in at the MSB leaves bit 0 at the bottom
                  shift_q <= {rx_s_q, shift_q[7:1]};
                  idx_q   <= idx_q + 1'b1;
                  if (idx_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               cnt_q <= cnt_d;
               if (tick) begin
                  fe_q    <= ~rx_s_q;
                  state_q <= rx_s_q ? IDLE : BREAK;
               end
            end
            BREAK: if (rx_s_q) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         // A good frame wins over an ack at the same edge: the new byte replaces the acked one
         if (good && (!ready_q || dato_ack)) begin
            dato_q  <= shift_q;
            ready_q <= 1'b1;
         end else if (good) begin
            ovr_q <= 1'b1;
         end else if (dato_ack && ready_q) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_b13_serial_rx.sv
// tb_b13_serial_rx: directed and random frames checked each cycle against a timing-arithmetic receiver model.
module tb_b13_serial_rx;
   localparam int BT   = 16;
   localparam int HALF = BT / 2;

   logic       clock = 1'b0, reset = 1'b1, rx_in = 1'b1, dato_ack = 1'b0;
   logic [7:0] dato;
   logic       dato_ready, dsr, frame_error, overrun;

   b13_serial_rx #(.BIT_TICKS(BT), .CNT_W(7)) dut (
      .clock(clock), .reset(reset), .rx_in(rx_in), .dato(dato), .dato_ready(dato_ready),
      .dato_ack(dato_ack), .dsr(dsr), .frame_error(frame_error), .overrun(overrun)
   );

   always #5 clock = ~clock;

   int   checks = 0, errors = 0, ncyc = 0, fe_cnt = 0, rise_edge = -1, e0 = 0;
   logic prev_rdy = 1'b0;
   bit   chk_on = 0, rnd = 0;

   logic       m_s1 = 1'b1, m_rxs = 1'b1;
   logic [7:0] e_dato = 8'h00;
   logic       e_rdy = 1'b0, e_fe = 1'b0, e_ovr = 1'b0;
   int         mode = 0, t0 = 0;
   bit         hist [int];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ncyc);
      end
   endfunction

   // mode 0 = waiting for a low line, 1 = inside a frame started at t0, 2 = waiting for line high
   task automatic model_step(input logic r, input logic rx, input logic a);
      logic       seen, good;
      logic [7:0] b;
      ncyc++;
      seen = m_rxs;
      good = 1'b0;
      b    = 8'h00;
      e_fe = 1'b0;
      if (r) begin
         m_s1 = 1'b1; m_rxs = 1'b1; mode = 0;
         e_dato = 8'h00; e_rdy = 1'b0; e_ovr = 1'b0;
         return;
      end
      hist[ncyc] = seen;
      m_rxs = m_s1;
      m_s1  = rx;
      if (mode == 0) begin
         if (!seen) begin t0 = ncyc; mode = 1; end
      end else if (mode == 1) begin
         if (ncyc == t0 + HALF && seen) mode = 0;
         else if (ncyc == t0 + HALF + 9 * BT) begin
            for (int k = 0; k < 8; k++) b[k] = hist[t0 + HALF + (k + 1) * BT];
            if (seen) begin good = 1'b1; mode = 0; end
            else begin e_fe = 1'b1; mode = 2; end
         end
      end else if (seen) mode = 0;
      if (good && (!e_rdy || a)) begin e_dato = b; e_rdy = 1'b1; end
      else if (good) e_ovr = 1'b1;
      else if (a && e_rdy) begin e_rdy = 1'b0; e_ovr = 1'b0; end
   endtask

   task automatic cycle(input logic r, input logic rx, input logic a);
      @(negedge clock);
      reset = r; rx_in = rx; dato_ack = a;
      @(posedge clock);
      model_step(r, rx, a);
      chk_on = 1;
      #1;
   endtask

   function automatic logic rack();
      return rnd && $urandom_range(0, 24) == 0;
   endfunction

   task automatic idle(input int n, input logic rx = 1'b1);
      for (int i = 0; i < n; i++) cycle(1'b0, rx, rack());
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stp, input int ack_at, input int len = 10 * BT);
      logic [9:0] f;
      f  = {stp, b, 1'b0};
      e0 = ncyc + 1;
      for (int i = 0; i < len; i++) cycle(1'b0, f[i / BT], (i == ack_at) || rack());
   endtask

   always @(negedge clock) if (chk_on) begin
      chk("dato", dato, e_dato);
      chk("dato_ready", dato_ready, e_rdy);
      chk("dsr", dsr, !e_rdy);
      chk("frame_error", frame_error, e_fe);
      chk("overrun", overrun, e_ovr);
      if (frame_error) fe_cnt++;
      if (dato_ready && !prev_rdy) rise_edge = ncyc;
      prev_rdy = dato_ready;
   end

   initial begin
      logic stp;
      repeat (3) cycle(1'b1, 1'b1, 1'b0);
      idle(200);
      chk("idle_ready", dato_ready, 0);
      chk("idle_dsr", dsr, 1);
      chk("idle_fe_count", fe_cnt, 0);
      chk("idle_overrun", overrun, 0);

      send_frame(8'hA5, 1'b1, -1);
      chk("a5_dato", dato, 8'hA5);
      chk("a5_ready", dato_ready, 1);
      chk("a5_dsr", dsr, 0);
      chk("a5_latency", rise_edge - e0, 154);
      cycle(1'b0, 1'b1, 1'b1);
      chk("a5_ack_ready", dato_ready, 0);
      chk("a5_ack_dsr", dsr, 1);
      idle(10);

      repeat (4) cycle(1'b0, 1'b0, 1'b0);
      idle(30);
      chk("false_ready", dato_ready, 0);
      chk("false_fe_count", fe_cnt, 0);
      chk("false_dato", dato, 8'hA5);
      send_frame(8'h3C, 1'b1, -1);
      idle(4);
      chk("3c_dato", dato, 8'h3C);
      chk("3c_ready", dato_ready, 1);
      cycle(1'b0, 1'b1, 1'b1);
      idle(10);

      send_frame(8'h81, 1'b0, -1);
      idle(20, 1'b0);
      idle(30);
      chk("ferr_count", fe_cnt, 1);
      chk("ferr_ready", dato_ready, 0);
      chk("ferr_dato", dato, 8'h3C);
      send_frame(8'h55, 1'b1, -1);
      idle(4);
      chk("55_dato", dato, 8'h55);
      chk("55_ready", dato_ready, 1);
      cycle(1'b0, 1'b1, 1'b1);
      idle(10);

      send_frame(8'h11, 1'b1, -1);
      idle(2);
      send_frame(8'h22, 1'b1, -1);
      idle(4);
      chk("ovr_dato", dato, 8'h11);
      chk("ovr_flag", overrun, 1);
      chk("ovr_ready", dato_ready, 1);
      cycle(1'b0, 1'b1, 1'b1);
      chk("ovr_ack_ready", dato_ready, 0);
      chk("ovr_ack_flag", overrun, 0);
      idle(10);

      send_frame(8'h11, 1'b1, -1);
      idle(2);
      send_frame(8'h22, 1'b1, 154);
      idle(4);
      chk("coinc_dato", dato, 8'h22);
      chk("coinc_ready", dato_ready, 1);
      chk("coinc_overrun", overrun, 0);
      cycle(1'b0, 1'b1, 1'b1);
      idle(10);

      send_frame(8'hC3, 1'b1, -1, 70);
      cycle(1'b1, 1'b1, 1'b0);
      chk("rst_dato", dato, 8'h00);
      chk("rst_ready", dato_ready, 0);
      chk("rst_dsr", dsr, 1);
      chk("rst_overrun", overrun, 0);
      chk("rst_fe", frame_error, 0);
      idle(200);
      chk("rst_fe_count", fe_cnt, 1);
      chk("rst_idle_ready", dato_ready, 0);

      rnd = 1;
      repeat (60) begin
         idle($urandom_range(0, 20));
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(1, 7)) cycle(1'b0, 1'b0, rack());
            idle($urandom_range(12, 30));
         end
         stp = $urandom_range(0, 7) != 0;
         send_frame(8'($urandom), stp, -1);
         if (!stp) idle($urandom_range(0, 30), 1'b0);
      end
      rnd = 0;
      idle(30);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/b13_serial_rx.md
Name: b13_serial_rx

Overview:
- Asynchronous-frame serial receiver: the receive end of the serial link driven by the b13 transmitter.
- Deserialises frames of 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with a fixed bit period.
- Holds one received byte for the downstream consumer under a ready/ack handshake.
- Reports framing errors and overruns, and drives dsr back toward the transmitter side.

Parameters:
- BIT_TICKS, 16, clock cycles per serial bit; legal range 4..(2^CNT_W)-1.
- CNT_W, 7, width of the bit-period counter.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_in  in  1  serial line; idle high; asynchronous to clock.
- dato  out  8  last accepted byte.
- dato_ready  out  1  high while an unread byte is held in dato.
- dato_ack  in  1  consumer acknowledge; single-cycle pulse.
- dsr  out  1  ready to receive; equals ~dato_ready.
- frame_error  out  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  out  1  sticky; set when a good frame completes while dato_ready=1.

Behaviour:
- Reset values:
  - dato=0x00, dato_ready=0, dsr=1, frame_error=0, overrun=0.
  - State=IDLE, counter=0, shift register=0.
  - Both synchroniser flops=1.
- Synchroniser: two flops, rx_in -> s1 -> rx_s. The FSM uses only rx_s. This adds 2 cycles of latency.
- HALF = floor(BIT_TICKS/2). The counter counts down; a "tick" is the cycle where counter==0, after which the counter reloads.
- States:
  - IDLE: on rx_s=0, load counter with HALF-1 and go to START. The edge on which START is entered is t0.
  - START: on tick, if rx_s=0, reload BIT_TICKS-1, clear bit index and go to DATA. If rx_s=1, this is a false start; return to IDLE with no outputs affected.
  - DATA: on each tick, shift rx_s into the MSB of the shift register (so LSB-first arrival ends aligned) and increment a 3-bit index. After the 8th sample (index wraps 7->0), go to STOP.
  - STOP: on tick, sample rx_s.
    - If 1 (good frame): go to IDLE.
    - If 0: pulse frame_error for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A line held at 0 never starts a new frame.
- Sample edges relative to t0: START at t0+HALF; data bit k (k=0..7) at t0+HALF+(k+1)*BIT_TICKS; STOP at t0+HALF+9*BIT_TICKS.
- Good frame at STOP edge:
  - If dato_ready=0, or dato_ack=1 in the same cycle: load dato and set dato_ready=1 at that edge; overrun is unchanged.
  - Otherwise: keep the old dato and set overrun=1.
- Handshake:
  - dato_ack with dato_ready=1 clears dato_ready and overrun at the next edge, unless a good frame completes at that same edge (rule above: new byte loaded, dato_ready stays 1).
  - dato_ack with dato_ready=0 is ignored.
  - dato is stable while dato_ready=1.
- dsr is combinational ~dato_ready. The receiver keeps receiving while dsr=0; there is no flow stall.
- Reset asserted mid-frame: next edge returns everything to reset values, the partial byte is lost, and no frame_error is raised.
- An 8-bit shift register plus a 3-bit index is sufficient; no arithmetic wider than CNT_W.

Test Plan:
- Reset, then line idle high for 200 cycles -> dato_ready=0, dsr=1, frame_error=0, overrun=0 throughout.
- Defaults; drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) with the start-bit fall first sampled at edge E0 -> dato=0xA5 and dato_ready=1, dsr=0 visible after edge E0+154; dato_ack pulse -> dato_ready=0 next cycle.
- rx_in low for only 4 cycles, then high -> START sample reads 1, FSM back to IDLE, no output changes; a following 0x3C frame is received correctly.
- Frame 0x81 with stop bit 0, line returns high 20 cycles later -> frame_error high exactly 1 cycle, dato_ready stays 0, dato unchanged; the next 0x55 frame is accepted.
- Two frames 0x11 then 0x22, no ack -> dato=0x11, overrun=1 after the second stop edge; ack -> dato_ready=0, overrun=0.
- Ack pulse coincident with the second frame's stop edge -> dato=0x22, dato_ready=1, overrun=0; separately, reset asserted mid-DATA -> reset values next edge, no frame_error.
